// File: rtl/clocking_pkg.sv
// Shared clocking definitions: sequencer state encoding, default timing
// constants and the divider width used by the clocking block.
package clocking_pkg;

  localparam int CLK_DIV_W         = 3;
  localparam int DEF_HOLD_CYCLES   = 4;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT  = 1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCKWAIT,
    ST_GATE,
    ST_APPLY,
    ST_SETTLE,
    ST_RELEASE
  } clkseq_state_t;

  function automatic logic cfg_equal(
    input logic [CLK_DIV_W-1:0] a_sel,
    input logic [CLK_DIV_W-1:0] a_sel2,
    input logic                 a_ext,
    input logic [CLK_DIV_W-1:0] b_sel,
    input logic [CLK_DIV_W-1:0] b_sel2,
    input logic                 b_ext
  );
    return (a_sel == b_sel) && (a_sel2 == b_sel2) && (a_ext == b_ext);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for slow level signals entering a clock domain.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetb_async,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge resetb_async) begin
    if (!resetb_async) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/clock_config_sequencer.sv
// Applies clock divider / source changes with a gate-apply-settle handshake,
// waits for PLL lock before using the PLL and falls back to external on lock loss.
module clock_config_sequencer
  import clocking_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int CNT_W         = 10
) (
  input  logic       pll_clk,
  input  logic       resetb_async,
  input  logic       pll_lock,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_sel,
  input  logic [2:0] req_sel2,
  input  logic       req_ext_clk_sel,
  output logic [2:0] sel,
  output logic [2:0] sel2,
  output logic       ext_clk_sel,
  output logic       clk_en,
  output logic       done,
  output logic       err_lock,
  output logic       lock_lost
);

  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT);

  logic                 lock_s;
  clkseq_state_t        state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CLK_DIV_W-1:0] req_sel_reg;
  logic [CLK_DIV_W-1:0] req_sel2_reg;
  logic                 req_ext_reg;
  logic [CLK_DIV_W-1:0] sel_reg;
  logic [CLK_DIV_W-1:0] sel2_reg;
  logic                 ext_reg;
  logic                 clk_en_reg;
  logic                 done_reg;
  logic                 err_lock_reg;
  logic                 lock_lost_reg;
  logic                 fallback_needed;
  logic                 accept;

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk          (pll_clk),
    .resetb_async (resetb_async),
    .d            (pll_lock),
    .q            (lock_s)
  );

  // Running on the PLL without lock: the fallback owns the next IDLE cycle.
  assign fallback_needed = !ext_reg && !lock_s;
  assign req_ready       = (state_reg == ST_IDLE) && !fallback_needed;
  assign accept          = req_valid && req_ready;

  always_ff @(posedge pll_clk or negedge resetb_async) begin
    if (!resetb_async) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      req_sel_reg   <= '0;
      req_sel2_reg  <= '0;
      req_ext_reg   <= 1'b1;
      sel_reg       <= '0;
      sel2_reg      <= '0;
      ext_reg       <= 1'b1;
      clk_en_reg    <= 1'b1;
      done_reg      <= 1'b0;
      err_lock_reg  <= 1'b0;
      lock_lost_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (state_reg == ST_IDLE && fallback_needed) begin
            req_sel_reg   <= sel_reg;
            req_sel2_reg  <= sel2_reg;
            req_ext_reg   <= 1'b1;
            lock_lost_reg <= 1'b1;
            cnt_reg       <= HOLD_LOAD;
            state_reg     <= ST_GATE;
          end else if (accept) begin
            req_sel_reg  <= req_sel;
            req_sel2_reg <= req_sel2;
            req_ext_reg  <= req_ext_clk_sel;
            if (cfg_equal(req_sel, req_sel2, req_ext_clk_sel, sel_reg, sel2_reg, ext_reg)) begin
              done_reg <= 1'b1;
            end else if (!req_ext_clk_sel && !lock_s) begin
              cnt_reg   <= TIMEOUT_LOAD;
              state_reg <= ST_LOCKWAIT;
            end else begin
              cnt_reg   <= HOLD_LOAD;
              state_reg <= ST_GATE;
            end
          end
        end
        ST_LOCKWAIT: begin
          if (lock_s) begin
            cnt_reg   <= HOLD_LOAD;
            state_reg <= ST_GATE;
          end else if (cnt_reg == '0) begin
            err_lock_reg <= 1'b1;
            done_reg     <= 1'b1;
            state_reg    <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_GATE: begin
          clk_en_reg <= 1'b0;
          if (cnt_reg == '0) begin
            state_reg <= ST_APPLY;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_APPLY: begin
          sel_reg   <= req_sel_reg;
          sel2_reg  <= req_sel2_reg;
          ext_reg   <= req_ext_reg;
          cnt_reg   <= SETTLE_LOAD;
          state_reg <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_reg == '0) begin
            state_reg <= ST_RELEASE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_RELEASE: begin
          clk_en_reg <= 1'b1;
          done_reg   <= 1'b1;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sel         = sel_reg;
  assign sel2        = sel2_reg;
  assign ext_clk_sel = ext_reg;
  assign clk_en      = clk_en_reg;
  assign done        = done_reg;
  assign err_lock    = err_lock_reg;
  assign lock_lost   = lock_lost_reg;

endmodule

// File: tb/tb_clock_config_sequencer.sv
// Directed bench: expected completions are queued when a request (or lock drop)
// is driven and checked against the outputs when done pulses.
module tb_clock_config_sequencer;

  localparam int HOLD    = 4;
  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 8;
  localparam int REL_LAT = HOLD + SETTLE + 2;

  logic       pll_clk = 1'b0;
  logic       resetb_async = 1'b0;
  logic       pll_lock = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_sel = '0;
  logic [2:0] req_sel2 = '0;
  logic       req_ext_clk_sel = 1'b1;
  logic [2:0] sel;
  logic [2:0] sel2;
  logic       ext_clk_sel;
  logic       clk_en;
  logic       done;
  logic       err_lock;
  logic       lock_lost;

  typedef struct {
    logic [2:0] sel;
    logic [2:0] sel2;
    logic       ext;
    logic       err;
    logic       lost;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   low_cnt  = 0;

  always #5 pll_clk = ~pll_clk;

  clock_config_sequencer #(
    .HOLD_CYCLES   (HOLD),
    .SETTLE_CYCLES (SETTLE),
    .LOCK_TIMEOUT  (TIMEOUT),
    .CNT_W         (10)
  ) dut (
    .pll_clk         (pll_clk),
    .resetb_async    (resetb_async),
    .pll_lock        (pll_lock),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_sel         (req_sel),
    .req_sel2        (req_sel2),
    .req_ext_clk_sel (req_ext_clk_sel),
    .sel             (sel),
    .sel2            (sel2),
    .ext_clk_sel     (ext_clk_sel),
    .clk_en          (clk_en),
    .done            (done),
    .err_lock        (err_lock),
    .lock_lost       (lock_lost)
  );

  always @(negedge pll_clk) begin
    if (done === 1'b1) done_cnt++;
    if (clk_en !== 1'b1) low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pll_clk);
      #1;
    end
  endtask

  task automatic push(input logic [2:0] s, input logic [2:0] s2, input logic e,
                      input logic er, input logic lo);
    exp_t x;
    x.sel = s; x.sel2 = s2; x.ext = e; x.err = er; x.lost = lo;
    sb_q.push_back(x);
  endtask

  task automatic drive_req(input string tag, input logic [2:0] s, input logic [2:0] s2, input logic e);
    req_sel = s; req_sel2 = s2; req_ext_clk_sel = e; req_valid = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge pll_clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc, output int n);
    n = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge pll_clk);
      #1;
      n++;
      if (done === 1'b1) return;
    end
    check({tag, "_done_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t x;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    x = sb_q.pop_front();
    exp_done++;
    check({tag, "_done"},      32'(done),        32'd1);
    check({tag, "_sel"},       32'(sel),         32'(x.sel));
    check({tag, "_sel2"},      32'(sel2),        32'(x.sel2));
    check({tag, "_ext"},       32'(ext_clk_sel), 32'(x.ext));
    check({tag, "_err_lock"},  32'(err_lock),    32'(x.err));
    check({tag, "_lock_lost"}, 32'(lock_lost),   32'(x.lost));
    check({tag, "_clk_en"},    32'(clk_en),      32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sel"},       32'(sel),         32'd0);
    check({tag, "_sel2"},      32'(sel2),        32'd0);
    check({tag, "_ext"},       32'(ext_clk_sel), 32'd1);
    check({tag, "_clk_en"},    32'(clk_en),      32'd1);
    check({tag, "_ready"},     32'(req_ready),   32'd1);
    check({tag, "_err_lock"},  32'(err_lock),    32'd0);
    check({tag, "_lock_lost"}, 32'(lock_lost),   32'd0);
    check({tag, "_done"},      32'(done),        32'd0);
  endtask

  initial begin
    int n;
    int low0;

    // Reset values, during and after reset
    #23;
    check_reset_vals("rst_during");
    @(negedge pll_clk);
    resetb_async = 1'b1;
    step(1);
    check_reset_vals("rst_after");

    // Normal switch to PLL with lock held
    pll_lock = 1'b1;
    step(3);
    push(3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
    drive_req("pll", 3'd2, 3'd3, 1'b0);
    check("pll_e0_clk_en", 32'(clk_en), 32'd1);
    step(1);
    check("pll_e1_clk_en", 32'(clk_en), 32'd0);
    step(HOLD - 1);
    check("pll_pre_apply_sel", 32'(sel), 32'd0);
    step(1);
    check("pll_apply_sel", 32'(sel), 32'd2);
    check("pll_apply_ext", 32'(ext_clk_sel), 32'd0);
    check("pll_apply_clk_en", 32'(clk_en), 32'd0);
    wait_done("pll", 40, n);
    check("pll_release_edge", 32'(HOLD + 1 + n), 32'(REL_LAT));
    pop_check("pll");
    check("pll_ready_after", 32'(req_ready), 32'd1);
    step(1);
    check("pll_done_one_cycle", 32'(done), 32'd0);

    // Identical request: immediate done, no gating
    push(3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
    low0 = low_cnt;
    drive_req("same", 3'd2, 3'd3, 1'b0);
    pop_check("same");
    step(1);
    check("same_done_one_cycle", 32'(done), 32'd0);
    check("same_no_gate", 32'(low_cnt - low0), 32'd0);

    // Automatic fallback on lock loss, with a request held off meanwhile
    pll_lock = 1'b0;
    step(2);
    check("fb_ready_blocked", 32'(req_ready), 32'd0);
    req_sel = 3'd5; req_sel2 = 3'd1; req_ext_clk_sel = 1'b1; req_valid = 1'b1;
    push(3'd2, 3'd3, 1'b1, 1'b0, 1'b1);
    step(1);
    check("fb_lock_lost", 32'(lock_lost), 32'd1);
    check("fb_ready_busy", 32'(req_ready), 32'd0);
    step(1);
    check("fb_clk_en_gated", 32'(clk_en), 32'd0);
    wait_done("fb", 40, n);
    check("fb_release_edge", 32'(1 + n), 32'(REL_LAT));
    pop_check("fb");
    check("fb_req_ready_after", 32'(req_ready), 32'd1);
    push(3'd5, 3'd1, 1'b1, 1'b0, 1'b1);
    step(1);
    req_valid = 1'b0;
    wait_done("fb_req", 40, n);
    check("fb_req_release_edge", 32'(n), 32'(REL_LAT));
    pop_check("fb_req");

    // Lock timeout: PLL requested but lock never arrives
    push(3'd5, 3'd1, 1'b1, 1'b1, 1'b1);
    low0 = low_cnt;
    drive_req("tmo", 3'd4, 3'd6, 1'b0);
    wait_done("tmo", 40, n);
    check("tmo_latency", 32'(n), 32'(TIMEOUT + 1));
    pop_check("tmo");
    check("tmo_no_gate", 32'(low_cnt - low0), 32'd0);

    // Reset during SETTLE
    pll_lock = 1'b1;
    step(3);
    drive_req("mid", 3'd3, 3'd4, 1'b0);
    step(10);
    check("mid_settle_clk_en", 32'(clk_en), 32'd0);
    check("mid_settle_sel", 32'(sel), 32'd3);
    resetb_async = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    step(2);
    resetb_async = 1'b1;
    step(3);
    check("mid_no_done", 32'(done_cnt), 32'(exp_done));
    push(3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
    drive_req("fresh", 3'd1, 3'd1, 1'b0);
    wait_done("fresh", 40, n);
    check("fresh_release_edge", 32'(n), 32'(REL_LAT));
    pop_check("fresh");
    step(2);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("done_pulse_count", 32'(done_cnt), 32'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
